instr_fetch_unit: RTL

//   Instruction fetch stage sitting directly upstream of the CPU core. Takes the core's 8-bit PC
//   and reads the 16-bit instruction word from a byte-wide program memory in two beats: high byte

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads a 16-bit big-endian instruction word as two
// bytes from a byte-wide program memory and hands it to the core over a
// valid/ack handshake. Supports PC redirects mid-fetch and a per-byte stall
// watchdog that aborts the fetch and raises a sticky error flag.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ir_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic [ADDR_W:0]   mem_addr,
    output logic [15:0]       ir,
    output logic              ir_valid,
    output logic              fetch_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_HI = 2'd1,
        ST_RD_LO = 2'd2,
        ST_VALID = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc_lat;
    logic [7:0]         r_hi_byte;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic w_redirect;
    logic w_timeout;
    logic w_start;

    // Core moved the PC away from the address currently being fetched/held.
    assign w_redirect = (pc != r_pc_lat);

    // Last allowed stall cycle for the byte in flight.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Every path that (re)starts a fetch at the current pc: enable from idle,
    // ack with enable, or a redirect (an ack in VALID takes precedence over it).
    assign w_start = ((r_state == ST_IDLE) && en) ||
                     (((r_state == ST_RD_HI) || (r_state == ST_RD_LO)) && w_redirect) ||
                     ((r_state == ST_VALID) && ir_ack && en) ||
                     ((r_state == ST_VALID) && !ir_ack && w_redirect);

    // Fetch sequencer; all outputs are registered alongside the state.
    // NOTE: every register here, including the data path regs, has an async reset
    // value so no stale partial word can reach ir after reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pc_lat   <= '0;
            r_hi_byte  <= '0;
            r_wait_cnt <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            ir         <= NOP_WORD;
            ir_valid   <= 1'b0;
            fetch_err  <= 1'b0;
        end else if (w_start) begin
            // NOTE: non-blocking assignments throughout, so every register sees
            // the pre-edge values of the others regardless of statement order.
            r_pc_lat   <= pc;
            mem_addr   <= {pc, 1'b0};
            mem_rd     <= 1'b1;
            r_wait_cnt <= '0;
            ir         <= NOP_WORD;
            ir_valid   <= 1'b0;
            r_state    <= ST_RD_HI;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    mem_rd <= 1'b0;
                end
                ST_RD_HI, ST_RD_LO: begin
                    if (mem_ready) begin
                        r_wait_cnt <= '0;
                        if (r_state == ST_RD_HI) begin
                            r_hi_byte <= mem_rdata;
                            mem_addr  <= {r_pc_lat, 1'b1};
                            r_state   <= ST_RD_LO;
                        end else begin
                            ir       <= {r_hi_byte, mem_rdata};
                            ir_valid <= 1'b1;
                            mem_rd   <= 1'b0;
                            r_state  <= ST_VALID;
                        end
                    end else if (w_timeout) begin
                        // Abort: hand the core a NOP and flag the error.
                        fetch_err  <= 1'b1;
                        ir         <= NOP_WORD;
                        ir_valid   <= 1'b1;
                        mem_rd     <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_VALID;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_VALID: begin
                    // Ack without enable: release the word and park in IDLE.
                    if (ir_ack) begin
                        ir_valid <= 1'b0;
                        ir       <= NOP_WORD;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
